// File: rtl/uart_pkg.sv
// Shared UART definitions: state encoding, stop-length codes, bit-length limits
// and the IrDA-SIR pulse ratio, plus small helpers used by the transmitter.
package uart_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4
    } tx_state_e;

    localparam logic [1:0] STOP_1   = 2'b00;
    localparam logic [1:0] STOP_0P5 = 2'b01;
    localparam logic [1:0] STOP_2   = 2'b10;
    localparam logic [1:0] STOP_1P5 = 2'b11;

    localparam int BR_MIN = 16;

    // IrDA-SIR pulse occupies IRDA_NUM/2^IRDA_SHIFT of a bit period.
    localparam int IRDA_NUM   = 3;
    localparam int IRDA_SHIFT = 4;

    // One extra bit so that a two-stop-bit period of a 16-bit baud value fits.
    localparam int CNT_W = 17;

    function automatic logic [15:0] eff_bit_len(input logic [15:0] br,
                                                input logic [15:0] br_min);
        return (br < br_min) ? br_min : br;
    endfunction

    function automatic logic [CNT_W-1:0] stop_cycles(input logic [15:0] bl,
                                                     input logic [1:0]  code);
        logic [CNT_W-1:0] cycles;
        case (code)
            STOP_0P5: cycles = {2'b00, bl[15:1]};
            STOP_2:   cycles = {bl, 1'b0};
            STOP_1P5: cycles = {1'b0, bl} + {2'b00, bl[15:1]};
            default:  cycles = {1'b0, bl};
        endcase
        return cycles;
    endfunction

    function automatic logic [CNT_W-1:0] irda_pulse_len(input logic [15:0] bl);
        logic [19:0] prod;
        prod = 20'(bl) * 20'(IRDA_NUM);
        return CNT_W'(prod >> IRDA_SHIFT);
    endfunction

endpackage

// File: rtl/uart_transmitter_if.sv
// Word handshake between a producer and the UART transmitter.
interface uart_transmitter_if;

    logic       tx_vld;
    logic [8:0] tx_data;
    logic       tx_rdy;

    modport master (
        output tx_vld,
        output tx_data,
        input  tx_rdy
    );

    modport slave (
        input  tx_vld,
        input  tx_data,
        output tx_rdy
    );

endinterface

// File: rtl/uart_tx_bit_timer.sv
// Per-bit down-counter for the transmitter: reloaded at each bit boundary, it
// flags the final cycle of the bit and the leading IrDA pulse window.
module uart_tx_bit_timer
    import uart_pkg::*;
(
    input  logic             clk,
    input  logic             rstn,
    input  logic             load_i,
    input  logic [CNT_W-1:0] load_val_i,
    input  logic [CNT_W-1:0] pulse_len_i,
    output logic             done_o,
    output logic             irda_win_o
);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] elapsed_q, elapsed_d;
    logic             run_q, run_d;

    always_comb begin
        cnt_d     = cnt_q;
        elapsed_d = elapsed_q;
        run_d     = run_q;
        if (load_i) begin
            cnt_d     = load_val_i;
            elapsed_d = '0;
            run_d     = 1'b1;
        end else if (run_q) begin
            elapsed_d = elapsed_q + 1'b1;
            if (cnt_q == '0) begin
                run_d = 1'b0;
            end else begin
                cnt_d = cnt_q - 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            cnt_q     <= '0;
            elapsed_q <= '0;
            run_q     <= 1'b0;
        end else begin
            cnt_q     <= cnt_d;
            elapsed_q <= elapsed_d;
            run_q     <= run_d;
        end
    end

    assign done_o     = run_q && (cnt_q == '0);
    assign irda_win_o = run_q && (elapsed_q < pulse_len_i);

endmodule

// File: rtl/uart_transmitter.sv
// UART transmitter: start, 8/9 data bits LSB first, optional parity and
// 0.5/1/1.5/2 stop bits, with optional IrDA-SIR return-to-zero shaping.
module uart_transmitter
    import uart_pkg::*;
#(
    parameter int BR_MIN  = uart_pkg::BR_MIN,
    parameter int STATE_W = 8
) (
    input  logic                clk,
    input  logic                rstn,
    input  logic                tx_en,
    input  logic [15:0]         baud_rate,
    input  logic                word_len,
    input  logic                parity_en,
    input  logic                parity_type,
    input  logic [1:0]          stop_len,
    input  logic                irda_mode,
    uart_transmitter_if.slave   tx_if,
    output logic                tx_dout,
    output logic                tx_busy,
    output logic                tx_done_p,
    output logic [STATE_W-1:0]  tx_state
);

    tx_state_e        state_q, state_d;

    logic [15:0]      bl_in;
    logic [15:0]      bl_q;
    logic             wlen_q;
    logic             pen_q;
    logic             ptype_q;
    logic [1:0]       stop_q;
    logic             irda_q;

    logic [8:0]       shift_q;
    logic [3:0]       bitcnt_q;
    logic             par_q;

    logic             accept;
    logic             last_bit;
    logic             tmr_load;
    logic [CNT_W-1:0] tmr_val;
    logic [CNT_W-1:0] bit_val;
    logic [CNT_W-1:0] stop_val;
    logic [CNT_W-1:0] pulse_len;
    logic             tmr_done;
    logic             irda_win;
    logic             line_bit;

    assign bl_in     = eff_bit_len(baud_rate, 16'(BR_MIN));
    assign bit_val   = {1'b0, bl_q} - 1'b1;
    assign stop_val  = stop_cycles(bl_q, stop_q) - 1'b1;
    assign pulse_len = irda_pulse_len(bl_q);
    assign last_bit  = (bitcnt_q == (wlen_q ? 4'd8 : 4'd7));
    assign accept    = tx_if.tx_vld & tx_if.tx_rdy;

    uart_tx_bit_timer u_bit_timer (
        .clk         (clk),
        .rstn        (rstn),
        .load_i      (tmr_load),
        .load_val_i  (tmr_val),
        .pulse_len_i (pulse_len),
        .done_o      (tmr_done),
        .irda_win_o  (irda_win)
    );

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Every bit boundary reloads the timer with the length of the bit that follows.
    always_comb begin
        state_d  = state_q;
        tmr_load = 1'b0;
        tmr_val  = '0;
        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    state_d  = ST_START;
                    tmr_load = 1'b1;
                    tmr_val  = {1'b0, bl_in} - 1'b1;
                end
            end
            ST_START: begin
                if (tmr_done) begin
                    state_d  = ST_DATA;
                    tmr_load = 1'b1;
                    tmr_val  = bit_val;
                end
            end
            ST_DATA: begin
                if (tmr_done) begin
                    tmr_load = 1'b1;
                    if (!last_bit) begin
                        tmr_val = bit_val;
                    end else if (pen_q) begin
                        state_d = ST_PARITY;
                        tmr_val = bit_val;
                    end else begin
                        state_d = ST_STOP;
                        tmr_val = stop_val;
                    end
                end
            end
            ST_PARITY: begin
                if (tmr_done) begin
                    state_d  = ST_STOP;
                    tmr_load = 1'b1;
                    tmr_val  = stop_val;
                end
            end
            ST_STOP: begin
                if (tmr_done) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Frame configuration is frozen at accept so mid-frame input changes are harmless.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            bl_q     <= '0;
            wlen_q   <= 1'b0;
            pen_q    <= 1'b0;
            ptype_q  <= 1'b0;
            stop_q   <= STOP_1;
            irda_q   <= 1'b0;
            shift_q  <= '0;
            bitcnt_q <= '0;
            par_q    <= 1'b0;
        end else if (accept) begin
            bl_q     <= bl_in;
            wlen_q   <= word_len;
            pen_q    <= parity_en;
            ptype_q  <= parity_type;
            stop_q   <= stop_len;
            irda_q   <= irda_mode;
            shift_q  <= tx_if.tx_data;
            bitcnt_q <= '0;
            par_q    <= 1'b0;
        end else if ((state_q == ST_DATA) && tmr_done) begin
            shift_q  <= {1'b0, shift_q[8:1]};
            bitcnt_q <= bitcnt_q + 1'b1;
            par_q    <= par_q ^ shift_q[0];
        end
    end

    always_comb begin
        line_bit = 1'b1;
        case (state_q)
            ST_START:  line_bit = 1'b0;
            ST_DATA:   line_bit = shift_q[0];
            ST_PARITY: line_bit = par_q ^ ptype_q;
            default:   line_bit = 1'b1;
        endcase
    end

    // IrDA inverts the sense: only a logical 0 produces a short high pulse.
    always_comb begin
        tx_if.tx_rdy = rstn & tx_en & (state_q == ST_IDLE);
        tx_busy      = (state_q != ST_IDLE);
        tx_done_p    = (state_q == ST_STOP) && tmr_done;
        tx_state     = '0;
        tx_state[2:0] = state_q;
        if (state_q == ST_IDLE) begin
            tx_dout = ~irda_mode;
        end else if (irda_q) begin
            tx_dout = ~line_bit & irda_win;
        end else begin
            tx_dout = line_bit;
        end
    end

endmodule
